sprite_mux: RTL and testbench

//   Layer-select multiplexer in the VGA pixel pipeline. Picks one of M 12-bit RGB444

---
 rtl/sprite_mux_pkg.sv | 9 +
 rtl/sprite_mux_sel.sv | 39 +++
 rtl/sprite_mux.sv | 52 +++++
 tb/tb_sprite_mux.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/sprite_mux_pkg.sv
// Shared types and constants for the sprite/background layer multiplexer.
package sprite_mux_pkg;

   typedef logic [11:0] colour_t;

   localparam colour_t COLOUR_BLANK            = 12'h000;
   localparam colour_t DEFAULT_TRANSPARENT_KEY = 12'hF0F;

endpackage

// File: rtl/sprite_mux_sel.sv
// Combinational M-way colour selector with out-of-range blanking.
// Transparency fallback to source 0 is built only when SPRITE_MUX_TRANSPARENCY_EN is defined.
module sprite_mux_sel
   import sprite_mux_pkg::*;
#(
   parameter int unsigned M               = 2,
   parameter int unsigned B               = $clog2(M),
   parameter colour_t     TRANSPARENT_KEY = DEFAULT_TRANSPARENT_KEY
) (
   input  colour_t        src [M],
   input  logic [B-1:0]   s,
   output colour_t        colour
);

   logic in_range;

   // Equality scan rather than src[s]: unmatched indices fall through to blank, never X.
   always_comb begin
      colour   = COLOUR_BLANK;
      in_range = 1'b0;
      for (int unsigned k = 0; k < M; k++) begin
         if (32'(s) == k) begin
            colour   = src[k];
            in_range = 1'b1;
         end
      end
`ifdef SPRITE_MUX_TRANSPARENCY_EN
      if (in_range && (s != '0) && (colour == TRANSPARENT_KEY)) begin
         colour = src[0];
      end
`endif
   end

`ifndef SPRITE_MUX_TRANSPARENCY_EN
   logic unused_key;
   assign unused_key = ^{TRANSPARENT_KEY, in_range};
`endif

endmodule

// File: rtl/sprite_mux.sv
// Registered layer-select mux for the VGA pixel pipeline (one-clock latency).
// Optional transparency keying via macro SPRITE_MUX_TRANSPARENCY_EN.
module sprite_mux
   import sprite_mux_pkg::*;
#(
   parameter int unsigned M               = 2,
   parameter int unsigned B               = $clog2(M),
   parameter colour_t     TRANSPARENT_KEY = DEFAULT_TRANSPARENT_KEY
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [11:0]                      a,
   input  logic [11:0]                      b,
   input  logic [12*((M > 2) ? M-2 : 1)-1:0] ext,
   input  logic [B-1:0]                     s,
   output logic [11:0]                      colour_data
);

   colour_t src [M];
   colour_t sel_colour;

   assign src[0] = a;
   assign src[1] = b;

   if (M > 2) begin : g_ext
      for (genvar k = 2; k < M; k++) begin : g_slice
         assign src[k] = ext[12*(k-2) +: 12];
      end
   end else begin : g_no_ext
      logic unused_ext;
      assign unused_ext = ^ext;
   end

   sprite_mux_sel #(
      .M               (M),
      .B               (B),
      .TRANSPARENT_KEY (TRANSPARENT_KEY)
   ) u_sel (
      .src    (src),
      .s      (s),
      .colour (sel_colour)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         colour_data <= COLOUR_BLANK;
      end else begin
         colour_data <= sel_colour;
      end
   end

endmodule

// File: tb/tb_sprite_mux.sv
// Self-checking bench for sprite_mux: directed cases plus random stimulus vs a reference model.
module tb_sprite_mux;

   logic        clk;
   logic        rst_n;
   logic [11:0] a, b, ext3, ext2;
   logic [1:0]  s3;
   logic [0:0]  s2;
   logic [11:0] out3, out2;
   logic [11:0] exp3, exp2;
   int          n_checks;
   int          n_errors;

   sprite_mux #(.M(3)) dut3 (
      .clk         (clk),
      .rst_n       (rst_n),
      .a           (a),
      .b           (b),
      .ext         (ext3),
      .s           (s3),
      .colour_data (out3)
   );

   sprite_mux #(.M(2)) dut2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .a           (a),
      .b           (b),
      .ext         (ext2),
      .s           (s2),
      .colour_data (out2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Reference: which colour a mux of m sources should present for this selection.
   function automatic logic [11:0] ref_colour(input int m, input logic [11:0] ra,
                                              input logic [11:0] rb, input logic [11:0] re,
                                              input int sel);
      logic [11:0] pick;
      if (sel >= m) return 12'h000;
      case (sel)
         0:       pick = ra;
         1:       pick = rb;
         default: pick = re;
      endcase
`ifdef SPRITE_MUX_TRANSPARENCY_EN
      if (sel != 0 && pick == 12'hF0F) pick = ra;
`endif
      return pick;
   endfunction

   // Called just after a negedge with inputs already driven.
   task automatic tick(input string tag);
      logic [11:0] n3, n2;
      n3 = ref_colour(3, a, b, ext3, int'(s3));
      n2 = ref_colour(2, a, b, ext2, int'(s2));
      #1;
      check_eq({tag, "_hold3"}, out3, exp3);
      check_eq({tag, "_hold2"}, out2, exp2);
      @(posedge clk);
      #1;
      exp3 = n3;
      exp2 = n2;
      check_eq({tag, "_m3"}, out3, exp3);
      check_eq({tag, "_m2"}, out2, exp2);
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      a     = 12'hFFF;
      b     = 12'h000;
      ext3  = 12'h000;
      ext2  = 12'h000;
      s3    = 2'd0;
      s2    = 1'b0;
      exp3  = 12'h000;
      exp2  = 12'h000;

      #3;
      check_eq("reset_m3", out3, 12'h000);
      check_eq("reset_m2", out2, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;

      // Select a, then b.
      tick("sel_a");
      check_eq("sel_a_lit", out3, 12'hFFF);
      s3 = 2'd1; s2 = 1'b1;
      tick("sel_b");
      check_eq("sel_b_lit", out3, 12'h000);

      // Extended source and out-of-range on M=3.
      s3 = 2'd2; ext3 = 12'h0A5; a = 12'h123;
      tick("sel_ext");
      check_eq("sel_ext_lit", out3, 12'h0A5);
      s3 = 2'd3;
      tick("out_range");
      check_eq("out_range_lit", out3, 12'h000);

      // Transparent key on sprite layer.
      s3 = 2'd1; s2 = 1'b1; b = 12'hF0F; a = 12'h00F;
      tick("key_b");
`ifdef SPRITE_MUX_TRANSPARENCY_EN
      check_eq("key_b_lit", out3, 12'h00F);
`else
      check_eq("key_b_lit", out3, 12'hF0F);
`endif
      // Key on background layer passes unchanged.
      s3 = 2'd0; s2 = 1'b0; a = 12'hF0F;
      tick("key_a");
      check_eq("key_a_lit", out2, 12'hF0F);

      // Toggle select every clock.
      a = 12'h111; b = 12'h222;
      for (int i = 0; i < 8; i++) begin
         s3 = 2'(i % 2); s2 = 1'(i % 2);
         tick("toggle");
      end

      // Asynchronous reset pulse mid-stream.
      #2;
      rst_n = 1'b0;
      #1;
      exp3 = 12'h000;
      exp2 = 12'h000;
      check_eq("async_rst_m3", out3, 12'h000);
      check_eq("async_rst_m2", out2, 12'h000);
      @(posedge clk);
      #1;
      check_eq("rst_hold_m3", out3, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;
      s3 = 2'd1; s2 = 1'b1;
      tick("post_rst");
      check_eq("post_rst_lit", out3, 12'h222);

      // Random traffic, including key colours and X on unselected ext.
      for (int i = 0; i < 300; i++) begin
         a    = ($urandom_range(0, 7) == 0) ? 12'hF0F : 12'($urandom);
         b    = ($urandom_range(0, 4) == 0) ? 12'hF0F : 12'($urandom);
         ext3 = ($urandom_range(0, 4) == 0) ? 12'hF0F : 12'($urandom);
         ext2 = 12'($urandom);
         s3   = 2'($urandom_range(0, 3));
         s2   = 1'($urandom_range(0, 1));
         if (s3 < 2'd2 && $urandom_range(0, 3) == 0) ext3 = 12'hxxx;
         if (s3 == 2'd3 && $urandom_range(0, 1) == 0) ext3 = 12'hxxx;
         tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
